// File: rtl/am2901_useq.sv
// am2901_useq: microprogram sequencer with flags, return stack, loop counter and halt (optional SEQ_STACK_TRAP_EN)
module am2901_useq #(
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hold,
    input  logic [2:0]    seq_op,
    input  logic [AW-1:0] br_addr,
    input  logic [CW-1:0] ct_data,
    input  logic [2:0]    cond_sel,
    input  logic          cond_pol,
    input  logic          flag_ld,
    input  logic          z,
    input  logic          ovr,
    input  logic          c4,
    input  logic          f3,
    output logic [AW-1:0] uaddr,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          halted,
    output logic          trap
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] uaddr_q, uaddr_d, next_a;
    logic [PW:0]   sp_q, sp_d;
    logic [PW-1:0] top_q, top_d, top_m1;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [3:0]    flag_q, flag_d;
    logic          halted_q, halted_d, trap_q, trap_d;
    logic          cond, run, push, pop;
    logic [AW-1:0] stk_q [DEPTH];

    // The stack is a ring: top_q is the next write slot, so a push on full
    // silently overwrites the oldest entry while sp_q saturates at DEPTH.
    assign next_a    = uaddr_q + 1'b1;
    assign top_m1    = top_q - 1'b1;
    assign run       = !hold && !halted_q;
    assign cond      = (cond_sel[2] | flag_q[cond_sel[1:0]]) ^ cond_pol;
    assign stk_empty = sp_q == '0;
    assign stk_full  = sp_q == SP_FULL;
    assign uaddr     = uaddr_q;
    assign halted    = halted_q;
    assign trap      = trap_q;

    // Next-state decode of the sequencer opcode
    always_comb begin
        uaddr_d  = uaddr_q;
        ctr_d    = ctr_q;
        halted_d = halted_q;
        trap_d   = trap_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (run) begin
            uaddr_d = next_a;
            case (seq_op)
                3'd1: uaddr_d = br_addr;
                3'd2: uaddr_d = cond ? br_addr : next_a;
                3'd3: if (cond) begin
`ifdef SEQ_STACK_TRAP_EN
                    if (stk_full) begin
                        uaddr_d = '1;
                        trap_d  = 1'b1;
                    end else begin
                        push    = 1'b1;
                        uaddr_d = br_addr;
                    end
`else
                    push    = 1'b1;
                    uaddr_d = br_addr;
`endif
                end
                3'd4: if (cond && !stk_empty) begin
                    pop     = 1'b1;
                    uaddr_d = stk_q[top_m1];
                end
                3'd5: ctr_d = ct_data;
                3'd6: if (ctr_q != '0) begin
                    ctr_d   = ctr_q - 1'b1;
                    uaddr_d = br_addr;
                end
                3'd7: begin
                    uaddr_d  = uaddr_q;
                    halted_d = 1'b1;
                end
                default: uaddr_d = next_a;
            endcase
        end
        sp_d   = push ? (stk_full ? sp_q : sp_q + 1'b1) : pop ? sp_q - 1'b1 : sp_q;
        top_d  = push ? top_q + 1'b1 : pop ? top_m1 : top_q;
        flag_d = (run && flag_ld) ? {f3, c4, ovr, z} : flag_q;
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uaddr_q  <= '0;
            sp_q     <= '0;
            top_q    <= '0;
            ctr_q    <= '0;
            flag_q   <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            uaddr_q  <= uaddr_d;
            sp_q     <= sp_d;
            top_q    <= top_d;
            ctr_q    <= ctr_d;
            flag_q   <= flag_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // Stack storage needs no reset; sp_q alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) stk_q[top_q] <= next_a;
    end
endmodule

// File: tb/tb_am2901_useq.sv
// tb_am2901_useq: directed plus randomized check of am2901_useq against a queue-based reference model
module tb_am2901_useq;
    localparam int AW = 8, DEPTH = 4, CW = 8;

    logic          clk = 1'b0, reset_n = 1'b0, hold = 1'b0;
    logic [2:0]    seq_op = '0, cond_sel = 3'd4;
    logic [AW-1:0] br_addr = '0;
    logic [CW-1:0] ct_data = '0;
    logic          cond_pol = 1'b0, flag_ld = 1'b0, z = 1'b0, ovr = 1'b0, c4 = 1'b0, f3 = 1'b0;
    logic [AW-1:0] uaddr;
    logic          stk_empty, stk_full, halted, trap;

    int total = 0, bad = 0;
    int m_ua, m_ctr;
    int m_stk[$];
    bit m_flag[4];
    bit m_halt, m_trap;

    am2901_useq #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .seq_op(seq_op), .br_addr(br_addr),
        .ct_data(ct_data), .cond_sel(cond_sel), .cond_pol(cond_pol), .flag_ld(flag_ld),
        .z(z), .ovr(ovr), .c4(c4), .f3(f3), .uaddr(uaddr), .stk_empty(stk_empty),
        .stk_full(stk_full), .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ua = 0; m_ctr = 0; m_stk.delete();
        for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
        m_halt = 1'b0; m_trap = 1'b0;
    endtask

    // Reference: one microinstruction applied to abstract state
    task automatic model_step();
        bit c;
        int nxt;
        if (hold || m_halt) return;
        c = ((cond_sel >= 3'd4) ? 1'b1 : m_flag[cond_sel[1:0]]) ^ cond_pol;
        nxt = (m_ua + 1) % (1 << AW);
        case (seq_op)
            3'd0: m_ua = nxt;
            3'd1: m_ua = br_addr;
            3'd2: m_ua = c ? int'(br_addr) : nxt;
            3'd3: if (!c) m_ua = nxt;
                  else if (m_stk.size() == DEPTH) begin
`ifdef SEQ_STACK_TRAP_EN
                      m_ua = (1 << AW) - 1; m_trap = 1'b1;
`else
                      m_stk.delete(0); m_stk.push_back(nxt); m_ua = br_addr;
`endif
                  end else begin
                      m_stk.push_back(nxt); m_ua = br_addr;
                  end
            3'd4: if (c && m_stk.size() > 0) m_ua = m_stk.pop_back(); else m_ua = nxt;
            3'd5: begin m_ctr = ct_data; m_ua = nxt; end
            3'd6: if (m_ctr != 0) begin m_ctr--; m_ua = br_addr; end else m_ua = nxt;
            default: m_halt = 1'b1;
        endcase
        if (flag_ld) begin
            m_flag[0] = z; m_flag[1] = ovr; m_flag[2] = c4; m_flag[3] = f3;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".uaddr"}, 32'(uaddr), 32'(m_ua));
        check({tag, ".empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
        check({tag, ".full"}, 32'(stk_full), 32'(m_stk.size() == DEPTH));
        check({tag, ".halted"}, 32'(halted), 32'(m_halt));
        check({tag, ".trap"}, 32'(trap), 32'(m_trap));
    endtask

    task automatic step(input logic [2:0] op, input logic [AW-1:0] br, input string tag);
        seq_op = op; br_addr = br;
        model_step();
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #3;
        do_reset();
        step(3'd0, 8'h00, "cont1"); step(3'd0, 8'h00, "cont2"); step(3'd0, 8'h00, "cont3");
        check("seq_three", 32'(uaddr), 32'h3);
        step(3'd1, 8'hFF, "jmp_ff");
        step(3'd0, 8'h00, "wrap");
        check("wrap_zero", 32'(uaddr), 32'h0);
        step(3'd1, 8'h04, "jmp4");
        cond_sel = 3'd0; z = 1'b1; flag_ld = 1'b1;
        step(3'd2, 8'h40, "cjmp_old");
        check("cjmp_oldflag", 32'(uaddr), 32'h5);
        flag_ld = 1'b0; z = 1'b0;
        step(3'd2, 8'h40, "cjmp_new");
        check("cjmp_newflag", 32'(uaddr), 32'h40);
        cond_pol = 1'b1;
        step(3'd2, 8'h77, "cjmp_pol");
        cond_pol = 1'b0; cond_sel = 3'd4;
        step(3'd1, 8'h10, "jmp10");
        step(3'd3, 8'h20, "call20"); step(3'd0, 8'h00, "c21");
        step(3'd3, 8'h30, "call30"); step(3'd4, 8'h00, "ret22");
        check("ret_22", 32'(uaddr), 32'h22);
        step(3'd4, 8'h00, "ret11");
        check("ret_11", 32'(uaddr), 32'h11);
        check("empty_again", 32'(stk_empty), 32'h1);
        ct_data = 8'd2;
        step(3'd5, 8'h00, "ldct"); step(3'd1, 8'h05, "jmp5");
        for (int i = 0; i < 3; i++) step(3'd6, 8'h05, "rpct");
        check("loop_exit", 32'(uaddr), 32'h6);
        step(3'd1, 8'h50, "jmp50");
        for (int i = 0; i < 5; i++) step(3'd3, uaddr + 8'h10, "push5");
`ifdef SEQ_STACK_TRAP_EN
        check("trap_vec", 32'(uaddr), 32'hFF);
        check("trap_set", 32'(trap), 32'h1);
`else
        check("ovf_target", 32'(uaddr), 32'hA0);
`endif
        for (int i = 0; i < 5; i++) step(3'd4, 8'h00, "unwind");
        hold = 1'b1;
        step(3'd1, 8'h99, "hold_jmp");
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (m_halt && $urandom_range(3) == 0) do_reset();
            hold = ($urandom_range(7) == 0);
            cond_sel = 3'($urandom_range(7)); cond_pol = 1'($urandom);
            flag_ld = 1'($urandom); z = 1'($urandom); ovr = 1'($urandom);
            c4 = 1'($urandom); f3 = 1'($urandom);
            ct_data = 8'($urandom_range(3));
            seq_op = 3'($urandom_range(7));
            if (seq_op == 3'd7 && $urandom_range(15) != 0) seq_op = 3'd0;
            step(seq_op, 8'($urandom), "rand");
        end
        hold = 1'b0; cond_sel = 3'd4; cond_pol = 1'b0; flag_ld = 1'b0;
        do_reset();
        step(3'd3, 8'h07, "call7");
        step(3'd7, 8'h00, "halt");
        check("halted_up", 32'(halted), 32'h1);
        for (int i = 0; i < 4; i++) begin
            hold = 1'(i);
            step(3'd1, 8'h33, "halt_jmp");
            check("halt_freeze", 32'(uaddr), 32'h7);
        end
        hold = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_ua", 32'(uaddr), 32'h0);
        check("async_halt", 32'(halted), 32'h0);
        check("async_empty", 32'(stk_empty), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
